// File: rtl/regfile_access_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// regfile_access_ctrl: reads two operands, issues them to the ALU, writes back.
// Revision 1.0
// ============================================================================
module regfile_access_ctrl #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 4,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_ra,
  input  logic [ADDR_W-1:0] req_rb,
  input  logic [ADDR_W-1:0] req_rc,
  input  logic              req_wb,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  input  logic              res_valid,
  input  logic [DATA_W-1:0] res_data,
  output logic              rf_en,
  output logic              rf_rd,
  output logic              rf_wr,
  output logic [ADDR_W-1:0] rf_sel_o1,
  output logic [ADDR_W-1:0] rf_sel_o2,
  output logic [ADDR_W-1:0] rf_sel_i1,
  output logic [DATA_W-1:0] rf_ip1,
  input  logic [DATA_W-1:0] rf_op1,
  input  logic [DATA_W-1:0] rf_op2,
  output logic              busy,
  output logic              timeout_err
);

  localparam int               TMR_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_LATCH = 3'd2,
    S_ISSUE = 3'd3,
    S_EXEC  = 3'd4,
    S_WB    = 3'd5
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [ADDR_W-1:0]  ra_q;
  logic               wb_q;
  logic [TMR_W-1:0]   timer;
  logic               accept;
  logic               expired;

  // req_ready is itself a registered output, so accept is glitch-free.
  assign accept = req_valid & req_ready;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    expired   = 1'b0;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_READ;
      S_READ:  state_nxt = S_LATCH;
      S_LATCH: state_nxt = S_ISSUE;
      S_ISSUE: begin
        if (op_ready) state_nxt = wb_q ? S_EXEC : S_IDLE;
      end
      S_EXEC: begin
        if (res_valid) begin
          state_nxt = S_WB;
        end else if (timer == TMR_LAST) begin
          state_nxt = S_IDLE;
          expired   = 1'b1;
        end
      end
      S_WB:    state_nxt = accept ? S_READ : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      ra_q <= '0;
      wb_q <= 1'b0;
    end else if (accept) begin
      ra_q <= req_ra;
      wb_q <= req_wb;
    end
  end

  // Cleared on every pass through a non-EXEC state, so each EXEC starts at 0.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      timer <= '0;
    end else begin
      timer <= (state == S_EXEC) ? timer + TMR_W'(1) : '0;
    end
  end

  // Strobes are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      req_ready <= 1'b1;
      busy      <= 1'b0;
      op_valid  <= 1'b0;
      rf_rd     <= 1'b0;
      rf_wr     <= 1'b0;
      rf_en     <= 1'b0;
    end else begin
      req_ready <= (state_nxt == S_IDLE) || (state_nxt == S_WB);
      busy      <= (state_nxt != S_IDLE);
      op_valid  <= (state_nxt == S_ISSUE);
      rf_rd     <= (state_nxt == S_READ);
      rf_wr     <= (state_nxt == S_WB);
      rf_en     <= (state_nxt == S_READ) || (state_nxt == S_WB);
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      rf_sel_o1 <= '0;
      rf_sel_o2 <= '0;
    end else if (accept) begin
      rf_sel_o1 <= req_rb;
      rf_sel_o2 <= req_rc;
    end
  end

  // The regfile registers its read data, so it is valid during LATCH.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      op_a <= '0;
      op_b <= '0;
    end else if (state == S_LATCH) begin
      op_a <= rf_op1;
      op_b <= rf_op2;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      rf_sel_i1 <= '0;
      rf_ip1    <= '0;
    end else if ((state == S_EXEC) && res_valid) begin
      rf_sel_i1 <= ra_q;
      rf_ip1    <= res_data;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      timeout_err <= 1'b0;
    end else if (accept) begin
      timeout_err <= 1'b0;
    end else if (expired) begin
      timeout_err <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_access_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// tb_regfile_access_ctrl: directed and randomized operations checked against a
// transaction-level register-file model and the documented cycle timing.
module tb_regfile_access_ctrl;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 4;
  localparam int TIMEOUT = 16;
  localparam int NREG    = 2**ADDR_W;

  logic              clk;
  logic              clr;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_ra;
  logic [ADDR_W-1:0] req_rb;
  logic [ADDR_W-1:0] req_rc;
  logic              req_wb;
  logic              op_valid;
  logic              op_ready;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              res_valid;
  logic [DATA_W-1:0] res_data;
  logic              rf_en;
  logic              rf_rd;
  logic              rf_wr;
  logic [ADDR_W-1:0] rf_sel_o1;
  logic [ADDR_W-1:0] rf_sel_o2;
  logic [ADDR_W-1:0] rf_sel_i1;
  logic [DATA_W-1:0] rf_ip1;
  logic [DATA_W-1:0] rf_op1;
  logic [DATA_W-1:0] rf_op2;
  logic              busy;
  logic              timeout_err;

  regfile_access_ctrl #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_ra     (req_ra),
    .req_rb     (req_rb),
    .req_rc     (req_rc),
    .req_wb     (req_wb),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .op_a       (op_a),
    .op_b       (op_b),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .rf_en      (rf_en),
    .rf_rd      (rf_rd),
    .rf_wr      (rf_wr),
    .rf_sel_o1  (rf_sel_o1),
    .rf_sel_o2  (rf_sel_o2),
    .rf_sel_i1  (rf_sel_i1),
    .rf_ip1     (rf_ip1),
    .rf_op1     (rf_op1),
    .rf_op2     (rf_op2),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Register file attached to the DUT, with registered read data.
  logic [DATA_W-1:0] mem    [NREG];
  logic [DATA_W-1:0] ref_rf [NREG];
  logic              preload;
  int                wr_count;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < NREG; i++) mem[i] <= ref_rf[i];
      wr_count <= 0;
      rf_op1   <= '0;
      rf_op2   <= '0;
    end else begin
      if (rf_wr) begin
        mem[rf_sel_i1] <= rf_ip1;
        wr_count       <= wr_count + 1;
      end
      if (rf_rd) begin
        rf_op1 <= mem[rf_sel_o1];
        rf_op2 <= mem[rf_sel_o2];
      end
    end
  end

  int   checks;
  int   errors;
  logic exp_terr;
  int   pending_wr;

  // Presents one request at the current negedge and follows it to completion.
  // Returns at a negedge with the DUT idle, or in WB when stay_wb is set.
  task automatic do_op(input logic [ADDR_W-1:0] ra, input logic [ADDR_W-1:0] rb,
                       input logic [ADDR_W-1:0] rc, input logic wb, input int stall,
                       input int rdel, input bit stay_wb, input logic [DATA_W-1:0] res);
    logic [DATA_W-1:0] ea;
    logic [DATA_W-1:0] eb;
    int                wr0;
    bit                got;
    ea = ref_rf[rb];
    eb = ref_rf[rc];
    wr0 = wr_count + pending_wr;
    pending_wr = 0;

    checks++;
    if (req_ready !== 1'b1 || timeout_err !== exp_terr) begin
      errors++;
      $display("FAIL present: req_ready=%b timeout_err=%b, required 1/%b", req_ready, timeout_err, exp_terr);
    end
    req_valid = 1'b1; req_ra = ra; req_rb = rb; req_rc = rc; req_wb = wb;
    @(negedge clk);
    req_valid = 1'b0;
    req_ra = ADDR_W'($urandom); req_rb = ADDR_W'($urandom);
    req_rc = ADDR_W'($urandom); req_wb = 1'($urandom);
    exp_terr = 1'b0;
    checks++;
    if ({rf_rd, rf_en, rf_wr, req_ready, busy, op_valid, timeout_err} !== 7'b1100100) begin
      errors++;
      $display("FAIL read_cycle: rd/en/wr/rdy/busy/ov/terr=%b, required 1100100",
               {rf_rd, rf_en, rf_wr, req_ready, busy, op_valid, timeout_err});
    end
    checks++;
    if ({rf_sel_o1, rf_sel_o2} !== {rb, rc}) begin
      errors++;
      $display("FAIL read_sel: sel_o1=%0d sel_o2=%0d, required %0d %0d", rf_sel_o1, rf_sel_o2, rb, rc);
    end
    res_valid = 1'($urandom);
    res_data  = $urandom;
    @(negedge clk);
    res_valid = 1'b0;
    checks++;
    if ({rf_rd, rf_en, op_valid, busy} !== 4'b0001) begin
      errors++;
      $display("FAIL latch_cycle: rd/en/ov/busy=%b, required 0001", {rf_rd, rf_en, op_valid, busy});
    end
    op_ready = (stall == 0);
    @(negedge clk);
    checks++;
    if ({op_valid, op_a, op_b} !== {1'b1, ea, eb}) begin
      errors++;
      $display("FAIL issue: op_valid=%b op_a=%h op_b=%h, required 1 %h %h", op_valid, op_a, op_b, ea, eb);
    end
    for (int s = 0; s < stall; s++) begin
      res_valid = 1'($urandom);
      @(negedge clk);
      checks++;
      if ({op_valid, op_a, op_b} !== {1'b1, ea, eb}) begin
        errors++;
        $display("FAIL stall_hold: op_valid=%b op_a=%h op_b=%h, required 1 %h %h", op_valid, op_a, op_b, ea, eb);
      end
      if (s == stall - 1) op_ready = 1'b1;
    end
    @(negedge clk);
    op_ready  = 1'($urandom);
    res_valid = 1'b0;
    checks++;
    if (op_valid !== 1'b0) begin
      errors++;
      $display("FAIL handshake: op_valid=%b, required 0", op_valid);
    end
    if (!wb) begin
      checks++;
      if ({busy, req_ready, rf_wr} !== 3'b010 || wr_count !== wr0) begin
        errors++;
        $display("FAIL nowb_idle: busy/rdy/wr=%b writes=%0d, required 010 writes=%0d",
                 {busy, req_ready, rf_wr}, wr_count, wr0);
      end
      return;
    end
    got = 1'b0;
    for (int c = 0; c < TIMEOUT && !got; c++) begin
      checks++;
      if ({busy, req_ready, op_valid, rf_wr} !== 4'b1000) begin
        errors++;
        $display("FAIL exec_wait: busy/rdy/ov/wr=%b at exec cycle %0d, required 1000",
                 {busy, req_ready, op_valid, rf_wr}, c);
      end
      if (c == rdel) begin
        res_valid = 1'b1;
        res_data  = res;
        got       = 1'b1;
      end
      @(negedge clk);
      res_valid = 1'b0;
      res_data  = $urandom;
    end
    if (got) begin
      checks++;
      if ({rf_wr, rf_en, rf_rd, req_ready, busy} !== 5'b11011) begin
        errors++;
        $display("FAIL wb_strobe: wr/en/rd/rdy/busy=%b, required 11011", {rf_wr, rf_en, rf_rd, req_ready, busy});
      end
      checks++;
      if ({rf_sel_i1, rf_ip1} !== {ra, res}) begin
        errors++;
        $display("FAIL wb_data: sel_i1=%0d ip1=%h, required %0d %h", rf_sel_i1, rf_ip1, ra, res);
      end
      ref_rf[ra] = res;
      if (stay_wb) begin
        pending_wr = 1;
        return;
      end
      @(negedge clk);
      checks++;
      if ({rf_wr, busy, req_ready} !== 3'b001 || wr_count !== wr0 + 1) begin
        errors++;
        $display("FAIL wb_done: wr/busy/rdy=%b writes=%0d, required 001 writes=%0d",
                 {rf_wr, busy, req_ready}, wr_count, wr0 + 1);
      end
    end else begin
      exp_terr = 1'b1;
      checks++;
      if ({timeout_err, busy, req_ready, rf_wr} !== 4'b1010 || wr_count !== wr0) begin
        errors++;
        $display("FAIL timeout: terr/busy/rdy/wr=%b writes=%0d, required 1010 writes=%0d",
                 {timeout_err, busy, req_ready, rf_wr}, wr_count, wr0);
      end
    end
  endtask

  task automatic test_reset;
    clr     = 1'b0;
    preload = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: req_ready=%b, required 1", req_ready);
    end
    checks++;
    if ({op_valid, op_a, op_b, rf_en, rf_rd, rf_wr, rf_sel_o1, rf_sel_o2, rf_sel_i1,
         rf_ip1, busy, timeout_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: ov=%b a=%h b=%h en/rd/wr=%b%b%b sel=%0d/%0d/%0d ip1=%h busy=%b terr=%b, required all 0",
               op_valid, op_a, op_b, rf_en, rf_rd, rf_wr, rf_sel_o1, rf_sel_o2, rf_sel_i1,
               rf_ip1, busy, timeout_err);
    end
    preload = 1'b0;
    clr     = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    do_op(4'd3, 4'd1, 4'd2, 1'b1, 0, 2, 1'b0, 32'd12);
  endtask

  task automatic test_stall;
    do_op(4'd9, 4'd6, 4'd11, 1'b1, 4, 0, 1'b0, $urandom);
  endtask

  task automatic test_no_wb;
    do_op(4'd5, 4'd3, 4'd9, 1'b0, 1, 0, 1'b0, $urandom);
  endtask

  task automatic test_timeout;
    do_op(4'd7, 4'd1, 4'd2, 1'b1, 0, TIMEOUT, 1'b0, $urandom);
    do_op(4'd8, 4'd3, 4'd3, 1'b1, 1, TIMEOUT - 1, 1'b0, $urandom);
  endtask

  task automatic test_back_to_back;
    do_op(4'd4, 4'd2, 4'd3, 1'b1, 0, 1, 1'b1, $urandom);
    do_op(4'd4, 4'd4, 4'd4, 1'b1, 0, 0, 1'b0, $urandom);
  endtask

  task automatic test_reset_mid_exec;
    int wr0;
    bit saw_wr;
    wr0 = wr_count + pending_wr;
    pending_wr = 0;
    req_valid = 1'b1; req_ra = 4'd5; req_rb = 4'd1; req_rc = 4'd2; req_wb = 1'b1;
    op_ready  = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    op_ready = 1'b0;
    checks++;
    if ({busy, op_valid, req_ready} !== 3'b100) begin
      errors++;
      $display("FAIL pre_abort_exec: busy/ov/rdy=%b, required 100", {busy, op_valid, req_ready});
    end
    #2 clr = 1'b0;
    #1;
    checks++;
    if ({op_valid, op_a, op_b, rf_en, rf_rd, rf_wr, rf_sel_o1, rf_sel_o2, rf_sel_i1,
         rf_ip1, busy, timeout_err, req_ready} !== {{(3*DATA_W+3*ADDR_W+7){1'b0}}, 1'b1}) begin
      errors++;
      $display("FAIL async_abort: ov=%b a=%h b=%h en/rd/wr=%b%b%b sel=%0d/%0d/%0d ip1=%h busy=%b terr=%b rdy=%b, required all 0 rdy=1",
               op_valid, op_a, op_b, rf_en, rf_rd, rf_wr, rf_sel_o1, rf_sel_o2, rf_sel_i1,
               rf_ip1, busy, timeout_err, req_ready);
    end
    @(negedge clk);
    clr = 1'b1;
    exp_terr = 1'b0;
    saw_wr = 1'b0;
    for (int i = 0; i < 20; i++) begin
      res_valid = 1'($urandom);
      res_data  = $urandom;
      @(negedge clk);
      if (rf_wr) saw_wr = 1'b1;
    end
    res_valid = 1'b0;
    checks++;
    if (saw_wr || wr_count !== wr0 || busy !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_no_write: saw_wr=%b writes=%0d busy=%b rdy=%b, required 0 writes=%0d 0 1",
               saw_wr, wr_count, busy, req_ready, wr0);
    end
  endtask

  task automatic test_random;
    logic wb;
    int   rdel;
    bit   stay;
    for (int n = 0; n < 40; n++) begin
      wb   = 1'($urandom);
      rdel = $urandom_range(0, TIMEOUT + 1);
      stay = wb && (rdel < TIMEOUT) && (n < 39) && ($urandom_range(0, 1) == 1);
      do_op(ADDR_W'($urandom), ADDR_W'($urandom), ADDR_W'($urandom), wb,
            $urandom_range(0, 3), rdel, stay, $urandom);
      if (!stay) repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic test_regfile_contents;
    repeat (2) @(negedge clk);
    for (int i = 0; i < NREG; i++) begin
      checks++;
      if (mem[i] !== ref_rf[i]) begin
        errors++;
        $display("FAIL regfile[%0d]: got %h, required %h", i, mem[i], ref_rf[i]);
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    clk = 1'b0; clr = 1'b0; preload = 1'b0;
    req_valid = 1'b0; req_ra = '0; req_rb = '0; req_rc = '0; req_wb = 1'b0;
    op_ready = 1'b0; res_valid = 1'b0; res_data = '0;
    checks = 0; errors = 0; exp_terr = 1'b0; pending_wr = 0;
    for (int i = 0; i < NREG; i++) ref_rf[i] = $urandom;
    ref_rf[1] = 32'd5;
    ref_rf[2] = 32'd7;

    test_reset();
    test_basic();
    test_stall();
    test_no_wb();
    test_timeout();
    test_back_to_back();
    test_reset_mid_exec();
    test_random();
    test_regfile_contents();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
